// File: rtl/clkout_period_monitor_if.sv
// Bundles the divided-clock input, enable and measurement results of the
// clkout period monitor; master drives div_in/en, slave is the monitor.
interface clkout_period_monitor_if #(
    parameter int CNT_W = 16
);
    logic             div_in;
    logic             en;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             overflow;

    modport master (
        output div_in,
        output en,
        input  period,
        input  high_time,
        input  meas_valid,
        input  locked,
        input  overflow
    );

    modport slave (
        input  div_in,
        input  en,
        output period,
        output high_time,
        output meas_valid,
        output locked,
        output overflow
    );
endinterface

// File: rtl/clkout_period_monitor.sv
// Measures period and high time of the divided clock in clk cycles, reports
// lock once the period is stable and flags a stalled divider as overflow.
module clkout_period_monitor #(
    parameter int CNT_W      = 16,
    parameter int LOCK_COUNT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    clkout_period_monitor_if.slave  bus
);
    typedef enum logic {
        IDLE,
        MEAS
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       LOCK_TGT = 8'(LOCK_COUNT);

    state_t           state_q, state_d;
    logic             div_q, div_d;
    logic             div_prev_q, div_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] prev_period_q, prev_period_d;
    logic [7:0]       match_cnt_q, match_cnt_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             overflow_q, overflow_d;

    logic             rise;
    logic [7:0]       match_inc;

    assign rise      = div_q & ~div_prev_q;
    assign match_inc = (match_cnt_q == LOCK_TGT) ? match_cnt_q : match_cnt_q + 8'd1;

    always_comb begin
        state_d       = state_q;
        div_d         = bus.div_in;
        div_prev_d    = div_q;
        cnt_d         = cnt_q;
        hcnt_d        = hcnt_q;
        prev_period_d = prev_period_q;
        match_cnt_d   = match_cnt_q;
        first_d       = first_q;
        period_d      = period_q;
        high_time_d   = high_time_q;
        meas_valid_d  = 1'b0;
        locked_d      = locked_q;
        overflow_d    = overflow_q;

        if (!bus.en) begin
            // Disabling drops the lock history; period/high_time keep the last result.
            state_d     = IDLE;
            locked_d    = 1'b0;
            overflow_d  = 1'b0;
            match_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d     = MEAS;
                        cnt_d       = CNT_ONE;
                        hcnt_d      = CNT_ONE;
                        match_cnt_d = '0;
                        first_d     = 1'b1;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period_d      = cnt_q;
                        high_time_d   = hcnt_q;
                        meas_valid_d  = 1'b1;
                        prev_period_d = cnt_q;
                        cnt_d         = CNT_ONE;
                        hcnt_d        = CNT_ONE;
                        // The first result after arming has nothing to compare against.
                        if (first_q) begin
                            first_d = 1'b0;
                        end else if (cnt_q == prev_period_q) begin
                            match_cnt_d = match_inc;
                            if (match_inc == LOCK_TGT) begin
                                locked_d = 1'b1;
                            end
                        end else begin
                            match_cnt_d = '0;
                            locked_d    = 1'b0;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        overflow_d  = 1'b1;
                        locked_d    = 1'b0;
                        match_cnt_d = '0;
                        state_d     = IDLE;
                    end else begin
                        cnt_d  = cnt_q + CNT_ONE;
                        hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, div_q};
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            div_q         <= 1'b0;
            div_prev_q    <= 1'b0;
            cnt_q         <= '0;
            hcnt_q        <= '0;
            prev_period_q <= '0;
            match_cnt_q   <= '0;
            first_q       <= 1'b0;
            period_q      <= '0;
            high_time_q   <= '0;
            meas_valid_q  <= 1'b0;
            locked_q      <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            div_prev_q    <= div_prev_d;
            cnt_q         <= cnt_d;
            hcnt_q        <= hcnt_d;
            prev_period_q <= prev_period_d;
            match_cnt_q   <= match_cnt_d;
            first_q       <= first_d;
            period_q      <= period_d;
            high_time_q   <= high_time_d;
            meas_valid_q  <= meas_valid_d;
            locked_q      <= locked_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.period     = period_q;
    assign bus.high_time  = high_time_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.locked     = locked_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: doc/clkout_period_monitor.md
# clkout_period_monitor

Measures the divided clock produced by the frequency-divider stage (`clockout`, driven into this block as `div_in`) in units of the system clock. It reports the period and high time of every completed cycle of `div_in`, raises `locked` once the period is stable, and flags a stalled divider via a sticky `overflow`. It sits directly downstream of the divider, in the same `clk` domain, and is used for self-check and mode-switch confirmation.

## Interface
- `CNT_W`, default 16: width of the period and high-time counters and outputs.
- `LOCK_COUNT`, default 4: number of consecutive equal-period measurements required to assert `locked`; legal range 1..255.
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `div_in` input, 1 bit: divided clock from the divider stage; synchronous to `clk`; no synchronizer.
- `en` input, 1 bit: measurement enable.
- `period` output, `CNT_W` bits: `clk` cycles between the last two detected rising edges of `div_in`.
- `high_time` output, `CNT_W` bits: `clk` cycles `div_in` was sampled high within that period.
- `meas_valid` output, 1 bit: one-cycle pulse when `period` and `high_time` update.
- `locked` output, 1 bit: period stable for `LOCK_COUNT` consecutive matches.
- `overflow` output, 1 bit: sticky; period counter saturated without a rising edge.

## Operation
- Sample register: `div_q <= div_in` on every edge, and `div_prev <= div_q`. The rising-edge condition `rise = div_q & ~div_prev` is combinational.
- FSM states:
  - **IDLE**: counters are idle. On `rise` with `en=1`, go to MEAS with `cnt=1`, `hcnt=1`, `match_cnt=0`. No `meas_valid` is produced; the first edge only arms the block.
  - **MEAS**, on a cycle with `rise`:
    - `period<=cnt`, `high_time<=hcnt`, `meas_valid<=1`.
    - `prev_period<=cnt`.
    - `cnt<=1`, `hcnt<=1`.
  - **MEAS**, on a cycle without `rise`:
    - `cnt<=cnt+1`.
    - `hcnt<=hcnt+div_q`.
- Lock logic, evaluated on each `rise` in MEAS:
  - First measurement after arming: no comparison; `match_cnt` stays 0.
  - Later measurements with `cnt==prev_period`: `match_cnt` increments, saturating at `LOCK_COUNT`. `locked<=1` when the new `match_cnt` equals `LOCK_COUNT`.
  - Mismatch: `match_cnt<=0` and `locked<=0`, at the same edge as `meas_valid`.
- Overflow: in MEAS, if `cnt` is all ones and there is no `rise`:
  - `overflow<=1`, `locked<=0`, `match_cnt<=0`, next state IDLE.
  - `period` and `high_time` hold.
- Simultaneous `rise` and saturation: `rise` wins. The block publishes `period` = all ones, and `overflow` is not set.
- `en=0`: next state IDLE; `locked`, `overflow`, `match_cnt` and `meas_valid` clear. `period` and `high_time` hold. When `en` returns to 1, the first `rise` only arms.
- `rst` (at any time, including mid-measurement): state IDLE. All outputs and internal counters go to 0, including `div_q`, `div_prev`, `prev_period` and `match_cnt`.
- `high_time` is never greater than `period`. `div_in` stuck high also saturates `cnt` and sets `overflow`.

## Timing
- Reset values: `period=0`, `high_time=0`, `meas_valid=0`, `locked=0`, `overflow=0`.
- Latency: if `div_in` is sampled 1 at edge N (sampled 0 at N-1), `rise` is true during cycle N→N+1. `period`, `high_time`, `meas_valid` and `locked` update at edge N+1.
- `meas_valid` is high for exactly one cycle per detected rising edge, and never on the arming edge.
- Minimum measurable period is 2 (`div_in` toggling every `clk`). The maximum before overflow is 2^`CNT_W`-1.
- `overflow` asserts at the edge where the saturated `cnt` would otherwise have incremented.

## Test plan
- Reset: drive `rst=1` for 2 cycles while `div_in` toggles, then release → all outputs 0 during and after reset until the second post-reset rising edge; no `meas_valid` on the first edge.
- Divide-by-4 input (2 high, 2 low), `LOCK_COUNT=4` → `meas_valid` every 4 cycles with `period=4` and `high_time=2`; `locked` rises with the 5th `meas_valid` and stays 1.
- Mode switch from divide-by-4 to divide-by-6 (3 high, 3 low) while locked → the first `period=6` measurement drops `locked` at that `meas_valid`; relock occurs at the 5th consecutive `period=6` measurement.
- `CNT_W=4`, locked on period 4, then `div_in` held low → after 15 counted cycles `overflow=1` and `locked=0`, with `period` still 4. Resuming toggling gives measurements after one arming edge, and `overflow` stays 1 until `en=0` or `rst`.
- Mid-measurement `rst` pulse of 1 cycle while locked → the next edge shows all outputs 0, and the next rise only arms.
- `en=0` for 10 cycles while `div_in` toggles at period 4 → no `meas_valid`, `period=4` holds, `locked=0`. After `en=1`, the first `meas_valid` is at the second rising edge.
